// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared state encodings, sizes and helpers for the wb_arbiter slice
package wb_arbiter_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int ID_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FAULT = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [NUM_MASTERS-1:0] id_onehot(input logic [ID_W-1:0] id);
    return NUM_MASTERS'(1) << id;
  endfunction

endpackage

// File: rtl/wb_rr_select.sv
// rtl/wb_rr_select.sv - combinational round-robin grant select; WB_ARB_M0_PRIORITY_EN gives master 0 absolute priority
module wb_rr_select
  import wb_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        last,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   gnt_vld
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    // Scan starts one past the last winner and wraps, so the first hit is the fairest choice.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = last + ID_W'(i + 1);
      if (!gnt_vld && req[idx]) begin
        gnt_id  = idx;
        gnt_vld = 1'b1;
      end
    end
`ifdef WB_ARB_M0_PRIORITY_EN
    if (req[0]) begin
      gnt_id  = '0;
      gnt_vld = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - 4-master Wishbone arbiter with address-limit trap and slave timeout
// Optional feature macro: WB_ARB_M0_PRIORITY_EN (handled in wb_rr_select).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT    = 16'd1000,
  parameter logic [15:0] ADDR_LIMIT = 16'h8000,
  parameter logic [15:0] ERR_DATA   = 16'hdead
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  wbm_cyc_i,
  input  logic [3:0]  wbm_stb_i,
  input  logic [3:0]  wbm_we_i,
  input  logic [63:0] wbm_adr_i,
  input  logic [63:0] wbm_dat_i,
  output logic [15:0] wbm_dat_o,
  output logic [3:0]  wbm_ack_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [15:0] wbs_adr_o,
  output logic [15:0] wbs_dat_o,
  input  logic [15:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  output logic        bm_memv,
  output logic        bm_timeout,
  output logic [1:0]  bm_wbm_id,
  output logic [15:0] bm_addr,
  output logic        bm_we
);

  state_t          state_q, state_d;
  logic [3:0]      req;
  logic [ID_W-1:0] sel_id;
  logic            sel_vld;
  logic [15:0]     sel_adr, sel_dat;
  logic            sel_we, sel_viol;
  logic [ID_W-1:0] gnt_q, last_q;
  logic [15:0]     adr_q, dat_q, cnt_q, rdata_q, bm_addr_q;
  logic            we_q, tmo_q, bm_we_q;
  logic [ID_W-1:0] bm_id_q;
  logic            granted_cyc, tmo_hit;

  assign req = wbm_cyc_i & wbm_stb_i;

  wb_rr_select u_sel (
    .req    (req),
    .last   (last_q),
    .gnt_id (sel_id),
    .gnt_vld(sel_vld)
  );

  assign sel_adr     = wbm_adr_i[{sel_id, 4'b0000} +: 16];
  assign sel_dat     = wbm_dat_i[{sel_id, 4'b0000} +: 16];
  assign sel_we      = wbm_we_i[sel_id];
  assign sel_viol    = sel_adr >= ADDR_LIMIT;
  assign granted_cyc = wbm_cyc_i[gnt_q];
  assign tmo_hit     = cnt_q == TIMEOUT - 16'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sel_vld) state_d = sel_viol ? ST_FAULT : ST_BUSY;
      // A master abandoning its cycle beats a same-clock ack; an ack beats the timeout.
      ST_BUSY: begin
        if (!granted_cyc)                state_d = ST_IDLE;
        else if (wbs_ack_i || tmo_hit)   state_d = ST_RESP;
      end
      ST_FAULT: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd3;
      gnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      tmo_q     <= 1'b0;
      bm_id_q   <= '0;
      bm_addr_q <= '0;
      bm_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_vld) begin
            gnt_q <= sel_id;
            adr_q <= sel_adr;
            dat_q <= sel_dat;
            we_q  <= sel_we;
            cnt_q <= '0;
            if (sel_viol) begin
              bm_id_q   <= sel_id;
              bm_addr_q <= sel_adr;
              bm_we_q   <= sel_we;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 16'd1;
          if (granted_cyc) begin
            if (wbs_ack_i) begin
              rdata_q <= wbs_dat_i;
            end else if (tmo_hit) begin
              rdata_q   <= ERR_DATA;
              tmo_q     <= 1'b1;
              bm_id_q   <= gnt_q;
              bm_addr_q <= adr_q;
              bm_we_q   <= we_q;
            end
          end
        end
        ST_FAULT: rdata_q <= ERR_DATA;
        ST_RESP:  last_q  <= gnt_q;
        default: ;
      endcase
    end
  end

  assign wbs_cyc_o  = state_q == ST_BUSY;
  assign wbs_stb_o  = state_q == ST_BUSY;
  assign wbs_we_o   = (state_q == ST_BUSY) & we_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_dat_o  = dat_q;
  assign wbm_ack_o  = (state_q == ST_RESP) ? id_onehot(gnt_q) : 4'b0000;
  assign wbm_dat_o  = rdata_q;
  assign bm_memv    = state_q == ST_FAULT;
  assign bm_timeout = tmo_q;
  assign bm_wbm_id  = bm_id_q;
  assign bm_addr    = bm_addr_q;
  assign bm_we      = bm_we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed plus randomized checks of wb_arbiter against a transaction-level model
module tb_wb_arbiter;

  localparam logic [15:0] TMO   = 16'd16;
  localparam logic [15:0] LIMIT = 16'h8000;
  localparam logic [15:0] ERR   = 16'hdead;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr [4];
  logic [15:0] m_dat [4];
  logic [63:0] wbm_adr_i, wbm_dat_i;
  logic [15:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_dat_i, bm_addr;
  logic [3:0]  wbm_ack_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i;
  logic        bm_memv, bm_timeout, bm_we;
  logic [1:0]  bm_wbm_id;

  int n_tests = 0;
  int n_fail  = 0;
  int model_last;
  int w;
  int exp_order [5];

  assign wbm_adr_i = {m_adr[3], m_adr[2], m_adr[1], m_adr[0]};
  assign wbm_dat_i = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TMO), .ADDR_LIMIT(LIMIT), .ERR_DATA(ERR)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_we_i  (m_we),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .bm_memv   (bm_memv),
    .bm_timeout(bm_timeout),
    .bm_wbm_id (bm_wbm_id),
    .bm_addr   (bm_addr),
    .bm_we     (bm_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fair winner: first requester after the previous winner, wrapping round the four masters.
  function automatic int pick(input logic [3:0] req, input int last);
`ifdef WB_ARB_M0_PRIORITY_EN
    if (req[0]) return 0;
`endif
    for (int i = 1; i <= 4; i++)
      if (req[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  // One complete access from IDLE; d = slave wait in clocks (d >= TMO means it never answers).
  task automatic run_txn(input int d, input logic [15:0] sdata, input bit keep, output int wout);
    int          wi, len, seen;
    bit          viol, tmo;
    logic [15:0] exp_data;
    wi   = pick(m_cyc & m_stb, model_last);
    wout = wi;
    viol = m_adr[wi] >= LIMIT;
    tmo  = 1'b0;
    tick();
    if (viol) begin
      chk("memv_pulse", bm_memv, 1);
      chk("memv_no_tmo", bm_timeout, 0);
      chk("memv_no_cyc", wbs_cyc_o, 0);
      chk("memv_id", bm_wbm_id, wi);
      chk("memv_addr", bm_addr, m_adr[wi]);
      chk("memv_we", bm_we, m_we[wi]);
      tick();
      exp_data = ERR;
    end else begin
      chk("busy_cyc", wbs_cyc_o, 1);
      chk("busy_adr", wbs_adr_o, m_adr[wi]);
      chk("busy_we", wbs_we_o, m_we[wi]);
      if (m_we[wi]) chk("busy_wdat", wbs_dat_o, m_dat[wi]);
      len  = (d < int'(TMO)) ? d + 1 : int'(TMO);
      tmo  = d >= int'(TMO);
      seen = 0;
      for (int k = 0; k < len; k++) begin
        if (wbs_cyc_o && wbs_stb_o) seen++;
        if (k == d) begin
          wbs_ack_i = 1'b1;
          wbs_dat_i = sdata;
        end
        tick();
        wbs_ack_i = 1'b0;
      end
      chk("busy_len", seen, len);
      chk("cyc_dropped", wbs_cyc_o, 0);
      exp_data = tmo ? ERR : sdata;
    end
    chk("resp_ack", wbm_ack_o, 4'b0001 << wi);
    chk("resp_dat", wbm_dat_o, exp_data);
    chk("resp_tmo", bm_timeout, tmo);
    chk("resp_no_memv", bm_memv, 0);
    if (tmo) begin
      chk("tmo_id", bm_wbm_id, wi);
      chk("tmo_addr", bm_addr, m_adr[wi]);
    end
    model_last = wi;
    if (!keep) begin
      m_cyc[wi] = 1'b0;
      m_stb[wi] = 1'b0;
    end
    tick();
    chk("post_ack", wbm_ack_o, 0);
    chk("post_dat_hold", wbm_dat_o, exp_data);
    chk("post_tmo", bm_timeout, 0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    tick();
    tick();
    rst        = 1'b0;
    model_last = 3;
  endtask

  task automatic set_master(input int i, input bit we, input logic [15:0] adr, input logic [15:0] dat);
    m_cyc[i] = 1'b1;
    m_stb[i] = 1'b1;
    m_we[i]  = we;
    m_adr[i] = adr;
    m_dat[i] = dat;
  endtask

  initial begin
    logic [3:0] set;
    int         r, d;
    wbs_ack_i = 1'b0;
    wbs_dat_i = '0;
    for (int i = 0; i < 4; i++) begin
      m_adr[i] = '0;
      m_dat[i] = '0;
    end
`ifdef WB_ARB_M0_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();

    chk("rst_ack", wbm_ack_o, 0);
    chk("rst_cyc", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 0);
    chk("rst_sadr", wbs_adr_o, 0);
    chk("rst_mdat", wbm_dat_o, 0);
    chk("rst_bm", {bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we}, 0);

    set_master(1, 1'b0, 16'h0010, 16'h0000);
    run_txn(2, 16'h1234, 1'b0, w);
    chk("t1_winner", w, 1);

    set_master(2, 1'b1, 16'h9000, 16'h5555);
    run_txn(0, 16'h0000, 1'b0, w);
    chk("t3_winner", w, 2);

    set_master(3, 1'b1, 16'h7fff, 16'habcd);
    run_txn(0, 16'h0001, 1'b0, w);
    set_master(1, 1'b0, 16'h8000, 16'h0000);
    run_txn(0, 16'h0002, 1'b0, w);

    set_master(0, 1'b0, 16'h0040, 16'h0000);
    run_txn(100, 16'h0003, 1'b0, w);
    set_master(0, 1'b0, 16'h0044, 16'h0000);
    run_txn(int'(TMO) - 1, 16'h4321, 1'b0, w);

    do_reset();
    for (int i = 0; i < 4; i++) set_master(i, 1'b0, 16'h0100 * 16'(i), 16'h0000);
    for (int n = 0; n < 5; n++) begin
      run_txn(0, 16'(16'h0a00 + n), 1'b1, w);
      chk("t2_order", w, exp_order[n]);
    end
    m_cyc = '0;
    m_stb = '0;
    tick();

    set_master(1, 1'b0, 16'h0100, 16'h0000);
    tick();
    chk("drop_busy", wbs_cyc_o, 1);
    tick();
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    tick();
    chk("drop_idle", wbs_cyc_o, 0);
    chk("drop_noack", wbm_ack_o, 0);
    chk("drop_nopulse", {bm_memv, bm_timeout}, 0);
    tick();
    chk("drop_noack2", wbm_ack_o, 0);

    set_master(0, 1'b0, 16'h0020, 16'h0000);
    run_txn(1, 16'h0bbb, 1'b0, w);
    set_master(3, 1'b0, 16'h0200, 16'h0000);
    tick();
    tick();
    chk("rmid_busy", wbs_cyc_o, 1);
    rst = 1'b1;
    tick();
    chk("rmid_idle", wbs_cyc_o, 0);
    chk("rmid_noack", wbm_ack_o, 0);
    chk("rmid_nopulse", {bm_memv, bm_timeout}, 0);
    rst        = 1'b0;
    model_last = 3;
    m_cyc      = '0;
    m_stb      = '0;
    set_master(0, 1'b0, 16'h0030, 16'h0000);
    set_master(1, 1'b0, 16'h0034, 16'h0000);
    run_txn(1, 16'h0ccc, 1'b0, w);
    chk("rmid_next_m0", w, 0);
    run_txn(0, 16'h0ddd, 1'b0, w);

    for (int round = 0; round < 25; round++) begin
      set = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        if (set[i]) begin
          set_master(i, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32768, 65535))
                                                 : 16'($urandom_range(0, 32767)),
                     16'($urandom));
        end else begin
          m_cyc[i] = 1'($urandom_range(0, 1));
          m_stb[i] = 1'b0;
        end
      end
      while ((m_cyc & m_stb) != 4'b0000) begin
        r = int'($urandom_range(0, 9));
        d = (r < 6) ? r : (r == 6) ? int'(TMO) - 1 : (r == 7) ? int'(TMO) : 40;
        run_txn(d, 16'($urandom), 1'b0, w);
      end
      m_cyc = '0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
